// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and entry type for the instruction fetch queue.
package if_fetch_queue_pkg;

  localparam int FQ_DEPTH   = 4;
  localparam int FQ_AW      = 2;
  localparam int FQ_ENTRY_W = 96;

  // addi x0,x0,0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [FQ_AW:0]   FQ_FULL    = (FQ_AW+1)'(FQ_DEPTH);
  localparam logic [FQ_AW:0]   FQ_CNT_ONE = (FQ_AW+1)'(1);
  localparam logic [FQ_AW-1:0] FQ_PTR_ONE = FQ_AW'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
interface if_fetch_queue_if;
  import if_fetch_queue_pkg::*;

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_pc;
  logic [31:0]         in_pc4;
  logic [31:0]         in_inst;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_pc;
  logic [31:0]         out_pc4;
  logic [31:0]         out_inst;
  logic [FQ_AW:0]      count;

  // pipeline side: drives fetched tuples, redirects and decode acceptance
  modport master (
    output flush, in_valid, in_pc, in_pc4, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_pc4, out_inst, count
  );

  // queue side
  modport slave (
    input  flush, in_valid, in_pc, in_pc4, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_pc4, out_inst, count
  );

endinterface

// File: rtl/if_fetch_queue_fq_ram.sv
// Entry storage: synchronous write, asynchronous read, contents not reset.
module fq_ram
  import if_fetch_queue_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [FQ_AW-1:0] waddr,
  input  fq_entry_t        wdata,
  input  logic [FQ_AW-1:0] raddr,
  output fq_entry_t        rdata
);

  fq_entry_t mem [FQ_DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between IF and ID: in-order buffer with flush on redirect.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,   // active-high asynchronous reset despite the name
  if_fetch_queue_if.slave bus
);

  logic [FQ_AW-1:0] wr_ptr;
  logic [FQ_AW-1:0] rd_ptr;
  logic [FQ_AW:0]   cnt;
  logic             push;
  logic             pop;
  logic             not_empty;
  fq_entry_t        head;
  fq_entry_t        wdata;

  // a full queue refuses input even if the head is popped this cycle
  assign bus.in_ready = (cnt != FQ_FULL);
  assign not_empty    = (cnt != '0);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = not_empty & bus.out_ready;
  assign wdata        = '{pc: bus.in_pc, pc4: bus.in_pc4, inst: bus.in_inst};

  fq_ram u_ram (
    .clk   (clk),
    .we    (push & ~bus.flush),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // pointer and occupancy update; flush discards everything including this cycle's push/pop
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FQ_PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + FQ_PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + FQ_CNT_ONE;
        2'b01:   cnt <= cnt - FQ_CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // head presentation; an empty queue shows a NOP so ID never sees stale data
  always_comb begin
    bus.out_valid = not_empty;
    bus.out_pc    = '0;
    bus.out_pc4   = '0;
    bus.out_inst  = INST_NOP;
    if (not_empty) begin
      bus.out_pc   = head.pc;
      bus.out_pc4  = head.pc4;
      bus.out_inst = head.inst;
    end
  end

  assign bus.count = cnt;

  a_cnt_max:    assert property (@(posedge clk) disable iff (rst_n) cnt <= FQ_FULL);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst_n) !(push && cnt == FQ_FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst_n) !(pop && cnt == '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
`timescale 1ns/1ps
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  if_fetch_queue_if bus ();

  if_fetch_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ {pc[15:0], pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: an ordered list of tuples, emptied by reset or flush
  fq_entry_t q[$];

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = bus.in_valid && (q.size() < FQ_DEPTH);
      do_pop  = bus.out_ready && (q.size() > 0);
      if (bus.flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{pc: bus.in_pc, pc4: bus.in_pc4, inst: bus.in_inst});
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] epc, epc4, einst;
    ev    = (q.size() != 0);
    epc   = ev ? q[0].pc   : 32'h0;
    epc4  = ev ? q[0].pc4  : 32'h0;
    einst = ev ? q[0].inst : INST_NOP;
    chk("m_out_valid", 32'(bus.out_valid), 32'(ev));
    chk("m_in_ready",  32'(bus.in_ready),  32'(q.size() != FQ_DEPTH));
    chk("m_count",     32'(bus.count),     32'(q.size()));
    chk("m_out_pc",    bus.out_pc,   epc);
    chk("m_out_pc4",   bus.out_pc4,  epc4);
    chk("m_out_inst",  bus.out_inst, einst);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_pc4   = pc + 32'd4;
    bus.in_inst  = inst_of(pc);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev_pc;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0);
    step();
    step();
    rst_n = 1'b0;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'h0000_0013);
    chk("rst_out_pc", bus.out_pc, 32'h0);

    // 1: three back-to-back pushes with decode stalled
    set_in(1'b1, 32'h0); step();
    set_in(1'b1, 32'h4); step();
    set_in(1'b1, 32'h8); step();
    set_in(1'b0, 32'h0);
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_out_pc", bus.out_pc, 32'h0);
    chk("t1_out_inst", bus.out_inst, inst_of(32'h0));
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);

    // 2: fill, offer an extra tuple, then pop once
    set_in(1'b1, 32'hC); step();
    chk("t2_count_full", 32'(bus.count), 32'd4);
    set_in(1'b1, 32'h10); step();
    chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_count_held", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1; step();
    set_in(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    chk("t2_ready_again", 32'(bus.in_ready), 32'd1);
    chk("t2_count_pop", 32'(bus.count), 32'd3);
    chk("t2_head", bus.out_pc, 32'h4);
    bus.out_ready = 1'b1;
    step(); step();
    chk("t2_last_head", bus.out_pc, 32'hC);
    step();
    bus.out_ready = 1'b0;
    chk("t2_drained", 32'(bus.count), 32'd0);

    // 3: streaming with one entry in flight; 20 advances wrap pointers 5 times
    set_in(1'b1, 32'h100); step();
    bus.out_ready = 1'b1;
    prev_pc = 32'h100;
    for (int i = 1; i <= 20; i++) begin
      set_in(1'b1, 32'h100 + 32'(4 * i));
      step();
      chk("t3_count", 32'(bus.count), 32'd1);
      chk("t3_out_pc", bus.out_pc, 32'h100 + 32'(4 * i));
      prev_pc = bus.in_pc;
    end
    chk("t3_final_pc", bus.out_pc, 32'h150);
    set_in(1'b0, 32'h0);
    step();
    bus.out_ready = 1'b0;
    chk("t3_empty", 32'(bus.count), 32'd0);

    // 4: flush with concurrent push and pop at count 3
    set_in(1'b1, 32'h40); step();
    set_in(1'b1, 32'h44); step();
    set_in(1'b1, 32'h48); step();
    chk("t4_count3", 32'(bus.count), 32'd3);
    set_in(1'b1, 32'h4C);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    #1 chk("t4_ready_flush", 32'(bus.in_ready), 32'd1);
    step();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0);
    chk("t4_count0", 32'(bus.count), 32'd0);
    chk("t4_valid0", 32'(bus.out_valid), 32'd0);
    chk("t4_nop", bus.out_inst, 32'h0000_0013);
    set_in(1'b1, 32'h80); step();
    set_in(1'b0, 32'h0);
    chk("t4_head80", bus.out_pc, 32'h80);
    chk("t4_head80_pc4", bus.out_pc4, 32'h84);
    bus.out_ready = 1'b1; step();

    // 5: popping an empty queue does nothing
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_count", 32'(bus.count), 32'd0);
      chk("t5_nop", bus.out_inst, 32'h0000_0013);
    end
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h90); step();
    set_in(1'b0, 32'h0);
    chk("t5_head90", bus.out_pc, 32'h90);
    bus.out_ready = 1'b1; step();
    bus.out_ready = 1'b0;

    // 6: asynchronous reset mid-cycle with two entries held
    set_in(1'b1, 32'hA0); step();
    set_in(1'b1, 32'hA4); step();
    set_in(1'b0, 32'h0);
    chk("t6_count2", 32'(bus.count), 32'd2);
    #1 rst_n = 1'b1;
    #0.5;
    chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_count", 32'(bus.count), 32'd0);
    step();
    rst_n = 1'b0;
    set_in(1'b1, 32'h0); step();
    set_in(1'b0, 32'h0);
    chk("t6_head0", bus.out_pc, 32'h0);
    chk("t6_head0_inst", bus.out_inst, inst_of(32'h0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
